// File: rtl/dec_ex_if.sv
// Decode/execute stage bus: instruction fetch inputs and EX-stage results.
interface dec_ex_if;
    logic [31:0] instruction;
    logic [31:0] pc_if;
    logic [31:0] pc_plus_4_if;
    logic [31:0] ex_result;
    logic [4:0]  ex_rd;
    logic        ex_we;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        illegal;

    modport master (
        output instruction, pc_if, pc_plus_4_if,
        input  ex_result, ex_rd, ex_we, branch_taken, branch_target, illegal
    );

    modport slave (
        input  instruction, pc_if, pc_plus_4_if,
        output ex_result, ex_rd, ex_we, branch_taken, branch_target, illegal
    );
endinterface

// File: rtl/dec_ex.sv
// RV32I integer decode + execute stage with register file and ID/EX pipeline register.
// Optional macro DEC_EX_BYPASS_EN forwards the EX result into ID operand reads.
module dec_ex (
    input  logic     clk,
    input  logic     rst,
    dec_ex_if.slave  bus
);
    typedef enum logic [2:0] {
        K_ALU, K_LUI, K_AUIPC, K_JAL, K_JALR, K_BRANCH, K_ILLEGAL
    } kind_t;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;

    logic [31:0] rf_reg [32];

    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_u, imm_j, imm_b;
    logic [31:0] rs1_val, rs2_val;
    kind_t       kind;
    logic        alt, use_imm;
    logic [31:0] imm;

    logic        valid_reg;
    kind_t       kind_reg;
    logic [2:0]  funct3_reg;
    logic        alt_reg, use_imm_reg;
    logic [4:0]  rd_reg;
    logic [31:0] rs1v_reg, rs2v_reg, imm_reg, pc_reg, pc4_reg;

    logic [31:0] alu_b, alu_out;
    logic        br_cond;
    logic [31:0] ex_result, branch_target;
    logic [4:0]  ex_rd;
    logic        ex_we, branch_taken, illegal;

    assign opcode = bus.instruction[6:0];
    assign rd     = bus.instruction[11:7];
    assign funct3 = bus.instruction[14:12];
    assign rs1    = bus.instruction[19:15];
    assign rs2    = bus.instruction[24:20];
    assign funct7 = bus.instruction[31:25];

    assign imm_i = {{20{bus.instruction[31]}}, bus.instruction[31:20]};
    assign imm_u = {bus.instruction[31:12], 12'b0};
    assign imm_j = {{12{bus.instruction[31]}}, bus.instruction[19:12],
                    bus.instruction[20], bus.instruction[30:21], 1'b0};
    assign imm_b = {{20{bus.instruction[31]}}, bus.instruction[7],
                    bus.instruction[30:25], bus.instruction[11:8], 1'b0};

    // ex_we already excludes rd=x0, so a match never forwards into x0 reads.
`ifdef DEC_EX_BYPASS_EN
    assign rs1_val = (ex_we && ex_rd == rs1) ? ex_result : rf_reg[rs1];
    assign rs2_val = (ex_we && ex_rd == rs2) ? ex_result : rf_reg[rs2];
`else
    assign rs1_val = rf_reg[rs1];
    assign rs2_val = rf_reg[rs2];
`endif

    always_comb begin
        kind    = K_ILLEGAL;
        alt     = 1'b0;
        use_imm = 1'b0;
        imm     = '0;
        case (opcode)
            OPC_OP: begin
                if (funct7 == 7'h00 ||
                    (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5))) begin
                    kind = K_ALU;
                    alt  = bus.instruction[30];
                end
            end
            OPC_OP_IMM: begin
                use_imm = 1'b1;
                imm     = imm_i;
                alt     = (funct3 == 3'd5) && bus.instruction[30];
                if ((funct3 == 3'd1 && funct7 == 7'h00) ||
                    (funct3 == 3'd5 && (funct7 == 7'h00 || funct7 == 7'h20)) ||
                    (funct3 != 3'd1 && funct3 != 3'd5))
                    kind = K_ALU;
            end
            OPC_LUI:   begin kind = K_LUI;   imm = imm_u; end
            OPC_AUIPC: begin kind = K_AUIPC; imm = imm_u; end
            OPC_JAL:   begin kind = K_JAL;   imm = imm_j; end
            OPC_JALR: begin
                imm = imm_i;
                if (funct3 == 3'd0) kind = K_JALR;
            end
            OPC_BRANCH: begin
                imm = imm_b;
                if (funct3 != 3'd2 && funct3 != 3'd3) kind = K_BRANCH;
            end
            default: ;
        endcase
    end

    // A taken branch/jump in EX squashes the instruction being decoded now.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg   <= 1'b0;
            kind_reg    <= K_ALU;
            funct3_reg  <= '0;
            alt_reg     <= 1'b0;
            use_imm_reg <= 1'b0;
            rd_reg      <= '0;
            rs1v_reg    <= '0;
            rs2v_reg    <= '0;
            imm_reg     <= '0;
            pc_reg      <= '0;
            pc4_reg     <= '0;
        end else begin
            valid_reg   <= !branch_taken;
            kind_reg    <= kind;
            funct3_reg  <= funct3;
            alt_reg     <= alt;
            use_imm_reg <= use_imm;
            rd_reg      <= rd;
            rs1v_reg    <= rs1_val;
            rs2v_reg    <= rs2_val;
            imm_reg     <= imm;
            pc_reg      <= bus.pc_if;
            pc4_reg     <= bus.pc_plus_4_if;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) rf_reg[i] <= '0;
        end else if (ex_we) begin
            rf_reg[ex_rd] <= ex_result;
        end
    end

    always_comb begin
        alu_b   = use_imm_reg ? imm_reg : rs2v_reg;
        alu_out = '0;
        case (funct3_reg)
            3'd0: alu_out = alt_reg ? rs1v_reg - alu_b : rs1v_reg + alu_b;
            3'd1: alu_out = rs1v_reg << alu_b[4:0];
            3'd2: alu_out = {31'b0, $signed(rs1v_reg) < $signed(alu_b)};
            3'd3: alu_out = {31'b0, rs1v_reg < alu_b};
            3'd4: alu_out = rs1v_reg ^ alu_b;
            3'd5: alu_out = alt_reg ? 32'($signed(rs1v_reg) >>> alu_b[4:0])
                                    : rs1v_reg >> alu_b[4:0];
            3'd6: alu_out = rs1v_reg | alu_b;
            default: alu_out = rs1v_reg & alu_b;
        endcase
    end

    always_comb begin
        case (funct3_reg)
            3'd0:    br_cond = rs1v_reg == rs2v_reg;
            3'd1:    br_cond = rs1v_reg != rs2v_reg;
            3'd4:    br_cond = $signed(rs1v_reg) <  $signed(rs2v_reg);
            3'd5:    br_cond = $signed(rs1v_reg) >= $signed(rs2v_reg);
            3'd6:    br_cond = rs1v_reg <  rs2v_reg;
            3'd7:    br_cond = rs1v_reg >= rs2v_reg;
            default: br_cond = 1'b0;
        endcase
    end

    always_comb begin
        ex_result     = '0;
        ex_rd         = '0;
        ex_we         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        illegal       = 1'b0;
        if (valid_reg) begin
            case (kind_reg)
                K_ALU:   begin ex_result = alu_out;          ex_rd = rd_reg; end
                K_LUI:   begin ex_result = imm_reg;          ex_rd = rd_reg; end
                K_AUIPC: begin ex_result = pc_reg + imm_reg; ex_rd = rd_reg; end
                K_JAL: begin
                    ex_result     = pc4_reg;
                    ex_rd         = rd_reg;
                    branch_taken  = 1'b1;
                    branch_target = pc_reg + imm_reg;
                end
                K_JALR: begin
                    ex_result     = pc4_reg;
                    ex_rd         = rd_reg;
                    branch_taken  = 1'b1;
                    branch_target = (rs1v_reg + imm_reg) & ~32'd1;
                end
                K_BRANCH: begin
                    branch_taken  = br_cond;
                    branch_target = pc_reg + imm_reg;
                end
                default: illegal = 1'b1;
            endcase
            ex_we = (kind_reg != K_BRANCH) && (kind_reg != K_ILLEGAL) && (rd_reg != 5'd0);
        end
    end

    assign bus.ex_result     = ex_result;
    assign bus.ex_rd         = ex_rd;
    assign bus.ex_we         = ex_we;
    assign bus.branch_taken  = branch_taken;
    assign bus.branch_target = branch_target;
    assign bus.illegal       = illegal;
endmodule

// File: tb/tb_dec_ex.sv
// Randomized self-checking bench for dec_ex against an instruction-level reference model.
module tb_dec_ex;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dec_ex_if bus_if ();
    dec_ex dut (.clk(clk), .rst(rst), .bus(bus_if));

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        we;
        logic        taken;
        logic [31:0] target;
        logic        illegal;
    } exp_t;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    logic [31:0] regs [32];
    exp_t pend;
    bit bypass;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".result"},  bus_if.ex_result,            pend.result);
        chk({tag, ".rd"},      32'(bus_if.ex_rd),           32'(pend.rd));
        chk({tag, ".we"},      32'(bus_if.ex_we),           32'(pend.we));
        chk({tag, ".taken"},   32'(bus_if.branch_taken),    32'(pend.taken));
        chk({tag, ".target"},  bus_if.branch_target,        pend.target);
        chk({tag, ".illegal"}, 32'(bus_if.illegal),         32'(pend.illegal));
        $display("step %-10s ins=%08h res=%08h rd=%0d we=%0b tk=%0b tgt=%08h ill=%0b",
                 tag, bus_if.instruction, bus_if.ex_result, bus_if.ex_rd, bus_if.ex_we,
                 bus_if.branch_taken, bus_if.branch_target, bus_if.illegal);
    endtask

    // Operand as the ID stage should see it: pending EX write is visible only with bypass.
    function automatic logic [31:0] read_op(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (bypass && pend.we && pend.rd == r) return pend.result;
        return regs[r];
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [6:0]  opc, f7;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] imm_i, imm_b, imm_j, upper, y;
        logic        legal, writes, is_reg;
        e      = '0;
        opc    = ins[6:0];
        f3     = ins[14:12];
        f7     = ins[31:25];
        rd     = ins[11:7];
        imm_i  = 32'($signed(ins) >>> 20);
        imm_b  = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        imm_j  = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        upper  = {ins[31:12], 12'b0};
        legal  = 1'b1;
        writes = 1'b0;
        case (opc)
            7'h33, 7'h13: begin
                is_reg = (opc == 7'h33);
                y = is_reg ? b : imm_i;
                if (is_reg) legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                else if (f3 == 3'd1) legal = (f7 == 7'h00);
                else if (f3 == 3'd5) legal = (f7 == 7'h00 || f7 == 7'h20);
                writes = legal;
                case (f3)
                    3'd0: e.result = (is_reg && f7 == 7'h20) ? a - y : a + y;
                    3'd1: e.result = a << (y % 32);
                    3'd2: e.result = ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
                    3'd3: e.result = (a < y) ? 32'd1 : 32'd0;
                    3'd4: e.result = a ^ y;
                    3'd5: e.result = (f7 == 7'h20) ? 32'($signed(a) >>> (y % 32)) : a >> (y % 32);
                    3'd6: e.result = a | y;
                    default: e.result = a & y;
                endcase
            end
            7'h37: begin writes = 1'b1; e.result = upper; end
            7'h17: begin writes = 1'b1; e.result = pc + upper; end
            7'h6F: begin
                writes = 1'b1; e.result = pc + 32'd4;
                e.taken = 1'b1; e.target = pc + imm_j;
            end
            7'h67: begin
                legal = (f3 == 3'd0);
                writes = legal;
                if (legal) begin
                    e.result = pc + 32'd4;
                    e.taken  = 1'b1;
                    e.target = (a + imm_i) & 32'hFFFF_FFFE;
                end
            end
            7'h63: begin
                legal = (f3 != 3'd2 && f3 != 3'd3);
                if (legal) begin
                    e.target = pc + imm_b;
                    case (f3)
                        3'd0: e.taken = (a == b);
                        3'd1: e.taken = (a != b);
                        3'd4: e.taken = ($signed(a) <  $signed(b));
                        3'd5: e.taken = ($signed(a) >= $signed(b));
                        3'd6: e.taken = (a <  b);
                        default: e.taken = (a >= b);
                    endcase
                end
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            e = '0;
            e.illegal = 1'b1;
        end else if (!writes) begin
            e.result = '0;
        end else begin
            e.rd = rd;
            e.we = (rd != 5'd0);
        end
        return e;
    endfunction

    task automatic step(input logic [31:0] ins, input logic [31:0] pc, input string tag);
        exp_t e;
        bus_if.instruction  = ins;
        bus_if.pc_if        = pc;
        bus_if.pc_plus_4_if = pc + 32'd4;
        e = pend.taken ? exp_t'('0)
                       : model(ins, pc, read_op(ins[19:15]), read_op(ins[24:20]));
        @(posedge clk);
        if (pend.we) regs[pend.rd] = pend.result;
        pend = e;
        #1 check_outputs(tag);
    endtask

    function automatic logic [31:0] rand_ins();
        logic [31:0] r;
        logic [4:0]  rd, r1, r2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [2:0]  bf3 [6];
        bf3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        r  = $urandom;
        rd = 5'($urandom_range(0, 7));
        r1 = 5'($urandom_range(0, 7));
        r2 = 5'($urandom_range(0, 7));
        f3 = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 9))
            0, 1: begin
                f7 = (f3 == 3'd5 && r[0]) ? 7'h20 : 7'h00;
                if (f3 == 3'd1 || f3 == 3'd5) return {f7, r[24:20], r1, f3, rd, 7'h13};
                return {r[31:20], r1, f3, rd, 7'h13};
            end
            2, 3: begin
                f7 = ((f3 == 3'd0 || f3 == 3'd5) && r[0]) ? 7'h20 : 7'h00;
                return {f7, r2, r1, f3, rd, 7'h33};
            end
            4: return {r[31:12], rd, r[1] ? 7'h37 : 7'h17};
            5: return {r[31:12], rd, 7'h6F};
            6: return {r[31:20], r1, 3'd0, rd, 7'h67};
            7, 8: return {r[31:25], r2, r1, bf3[$urandom_range(0, 5)], r[11:7], 7'h63};
            default: return r;
        endcase
    endfunction

    initial begin
`ifdef DEC_EX_BYPASS_EN
        bypass = 1'b1;
`else
        bypass = 1'b0;
`endif
        for (int i = 0; i < 32; i++) regs[i] = '0;
        pend = '0;

        // Reset held across edges with an arbitrary instruction presented.
        bus_if.instruction  = 32'h0050_0093;
        bus_if.pc_if        = 32'h100;
        bus_if.pc_plus_4_if = 32'h104;
        #12 check_outputs("reset");
        @(posedge clk); #1 check_outputs("reset2");
        @(negedge clk) rst = 1'b1;

        step(32'h01F8_81B3, 32'd0, "rd_x31x17");      // add x3,x17,x31: reads 0 after reset
        step(32'h0050_0093, 32'd0, "addi");
        chk("addi.const", bus_if.ex_result, 32'd5);
        step(32'h0010_8133, 32'd4, "add_raw");
        chk("add_raw.const", bus_if.ex_result, bypass ? 32'd10 : 32'd0);
        step(32'h0000_0463, 32'd8, "beq");
        chk("beq.taken", 32'(bus_if.branch_taken), 32'd1);
        chk("beq.target", bus_if.branch_target, 32'd16);
        step(32'h0010_0193, 32'd12, "squash");
        chk("squash.we", 32'(bus_if.ex_we), 32'd0);
        step(32'h0100_00EF, 32'd4, "jal");
        chk("jal.result", bus_if.ex_result, 32'd8);
        chk("jal.target", bus_if.branch_target, 32'd20);
        step(32'h0010_0213, 32'd8, "squash2");
        step(32'h0070_2003, 32'd20, "load");
        chk("load.illegal", 32'(bus_if.illegal), 32'd1);
        step(32'h0070_0013, 32'd24, "addi_x0");
        step(32'h0000_02B3, 32'd28, "read_x0");
        chk("read_x0.const", bus_if.ex_result, 32'd0);

        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                rst = 1'b0;
                for (int i = 0; i < 32; i++) regs[i] = '0;
                pend = '0;
                #1 check_outputs("midreset");
                @(negedge clk) rst = 1'b1;
            end
            step(rand_ins(), {$urandom_range(0, 32'h3FFF), 2'b00}, "rand");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
